pe_host_driver: RTL and testbench
=================================

# pe_host_driver

Host-side initiator for the PE's pin-level command protocol: the block that drives a `tt_um_pe_mariam` instance the same way the cocotb bench does, but in synthesizable RTL. It accepts signed operand pairs on a valid/ready stream and sequences CLEAR/LOAD_A/MAC commands onto the PE's `ui_in`/`uio_in` pins. After the last pair it reads the accumulator back byte by byte from `uo_out` and returns it on a result stream. It sits between an FPGA/array controller and one PE instance.

## Interface
- `ACC_W`, 32, accumulator width in bits; multiple of 8, 8..32; readback bytes NB = ACC_W/8
- `READ_LAT`, 2, cycles from READ appearing on the pins to valid `uo_out`; 1..7
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `op_valid` in 1: operand pair valid
- `op_ready` out 1: driver accepts a pair
- `op_a` in 8: signed operand A
- `op_b` in 8: signed operand B
- `op_last` in 1: final pair of the dot product
- `res_valid` out 1: result valid
- `res_ready` in 1: consumer accepts result
- `res_data` out ACC_W: accumulator read back, byte 0 = LSB
- `res_count` out 16: MAC count (see Configuration)
- `pe_ui_in` out 8: to PE `ui_in` (operand byte)
- `pe_uio_in` out 8: to PE `uio_in`; [2:0] cmd, [4:3] byte select, [7:5] zero
- `pe_uo_out` in 8: from PE `uo_out`
- `pe_ena` out 1: to PE `ena`
- `busy` out 1: state ≠ IDLE

## Operation
- Command encoding on `pe_uio_in[2:0]`: 000 NOP, 001 LOAD_A (`ui_in` = A), 010 MAC (`ui_in` = B; acc += A·B), 011 READ (byte select = `[4:3]`), 100 CLEAR.
- The pins are a Moore decode of the state register plus the registered operand latch. There is no combinational path from `op_*` to the pins.
- FSM states and transitions:
  - INIT: NOP → CLR.
  - CLR: CLEAR → IDLE.
  - IDLE: `op_ready`=1. On handshake, latch A, B and last → LDA.
  - LDA: LOAD_A, `ui_in`=A → MAC.
  - MAC: MAC, `ui_in`=B.
    - If latched last → RD with byte index 0.
    - Else `op_ready`=1. On handshake → LDA with the new pair; otherwise → IDLE.
  - RD: READ with sel=i, held for READ_LAT+1 cycles. In the final cycle, `pe_uo_out` is captured into `res_data[8i+:8]`. If i = NB-1 → RES, else i+1 and stay in RD.
  - RES: `res_valid`=1, `res_data` stable. On handshake → CLR.
- `op_ready` is 0 in INIT, CLR, LDA, RD and RES, and 0 in MAC when last is latched.
- `pe_ui_in` is 0 in every state except LDA and MAC.
- `pe_ena` is 1 from the first edge after reset release, forever.
- The driver performs no arithmetic on operands. The signed product/sum is the PE's job; A and B are passed through as raw bytes.
- Reset values: `op_ready` 0, `res_valid` 0, `res_data` 0, `res_count` 0, `pe_ui_in` 0, `pe_uio_in` 0, `pe_ena` 0, `busy` 1 (state INIT).
- Reset mid-operation (any state): all outputs return to reset values immediately. The pending pair and partial readback are discarded. The sequence restarts at INIT → CLR, so the PE accumulator is always cleared.

## Timing
- After reset release: edge 1 → CLR (pins show CLEAR); edge 2 → IDLE (`op_ready`=1).
- Handshake at edge N: LOAD_A on pins for cycle N+1, MAC for cycle N+2.
- Throughput: back-to-back pairs every 2 cycles (acceptance in MAC).
- Readback latency, from MAC cycle to `res_valid`: NB·(READ_LAT+1) + 1 cycles; 13 cycles at the defaults.
- RES → CLR → IDLE: 2 cycles after the result handshake before the next `op_ready`.

## Configuration
- `PE_DRV_MACCNT_EN` defined:
  - A 16-bit counter increments on each MAC state. It saturates at 0xFFFF and is cleared in CLR.
  - The count is copied to `res_count` on entry to RES and held stable there.
- `PE_DRV_MACCNT_EN` undefined: no counter is built and `res_count` is tied to 0.

## Structure
- Package `pe_host_pkg` holds:
  - the command encodings (`PE_CMD_NOP`…`PE_CMD_CLEAR`);
  - the FSM state enum;
  - the `pe_uio_in` field positions.
- One sub-module, `pe_readback_shifter`, holds the byte index, the READ_LAT wait counter and the `res_data` assembly. The FSM lives in the top level.

## Test plan
- Reset: hold `rst_n`=0 → all outputs at reset values. Release → CLEAR (`uio_in`=0x04) in cycle 1, `op_ready`=1 in cycle 2.
- Single pair (A=3, B=4, last), with a PE behavioural model → pins carry 0x01/0x03 then 0x02/0x04; READ sel 0..3 each held 3 cycles; `res_data`=0x0000000C.
- Signed back-to-back pairs (-2,5),(7,-3 last) → second pair accepted during the first MAC cycle; `res_data`=0xFFFFFFE1.
- Backpressure: `res_ready`=0 for 10 cycles → `res_valid`, `res_data` and `res_count` stable and `op_ready`=0. Then handshake → CLEAR next cycle, `op_ready` one cycle after.
- Reset asserted during the RD byte-2 wait → outputs reset asynchronously, no `res_valid`. After release, CLEAR is issued before any new LOAD_A.
- Macro: 5 pairs with `PE_DRV_MACCNT_EN` → `res_count`=5; without the macro → `res_count`=0, `res_data` unchanged.

Source files
------------

// File: rtl/pe_host_pkg.sv
// Shared definitions for the PE host driver: pin command encodings, FSM states
// and the bit positions of the fields carried on pe_uio_in.
package pe_host_pkg;

  localparam int unsigned PE_CMD_W    = 3;
  localparam int unsigned PE_SEL_W    = 2;
  localparam int unsigned UIO_CMD_LSB = 0;
  localparam int unsigned UIO_SEL_LSB = 3;
  localparam int unsigned CNT_W       = 16;

  localparam logic [PE_CMD_W-1:0] PE_CMD_NOP    = 3'b000;
  localparam logic [PE_CMD_W-1:0] PE_CMD_LOAD_A = 3'b001;
  localparam logic [PE_CMD_W-1:0] PE_CMD_MAC    = 3'b010;
  localparam logic [PE_CMD_W-1:0] PE_CMD_READ   = 3'b011;
  localparam logic [PE_CMD_W-1:0] PE_CMD_CLEAR  = 3'b100;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CLR,
    ST_IDLE,
    ST_LDA,
    ST_MAC,
    ST_RD,
    ST_RES
  } pe_state_e;

  // Pack a command and byte select into the pe_uio_in layout; upper bits stay zero.
  function automatic logic [7:0] pe_uio(input logic [PE_CMD_W-1:0] cmd,
                                        input logic [PE_SEL_W-1:0] sel);
    logic [7:0] v;
    v = 8'h00;
    v[UIO_CMD_LSB +: PE_CMD_W] = cmd;
    v[UIO_SEL_LSB +: PE_SEL_W] = sel;
    return v;
  endfunction

endpackage

// File: rtl/pe_host_driver_if.sv
// Operand-in / result-out stream bundle between the array controller (master)
// and the PE host driver (slave).
interface pe_host_if #(
  parameter int unsigned ACC_W = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             op_last;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [15:0]      res_count;

  modport master (
    output op_valid, op_a, op_b, op_last, res_ready,
    input  op_ready, res_valid, res_data, res_count
  );

  modport slave (
    input  op_valid, op_a, op_b, op_last, res_ready,
    output op_ready, res_valid, res_data, res_count
  );
endinterface

// File: rtl/pe_readback_shifter.sv
// Sequences the accumulator readback: byte index, READ latency wait and
// assembly of the captured uo_out bytes into the result word.
module pe_readback_shifter #(
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned READ_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             active_i,
  input  logic [7:0]       uo_i,
  output logic [1:0]       idx_nxt_c,
  output logic             done_c,
  output logic [ACC_W-1:0] data_o
);
  localparam int unsigned NB     = ACC_W / 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned WAIT_W = 3;

  logic [IDX_W-1:0]  idx_q,  idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ACC_W-1:0]  data_q, data_d;

  // Capture on the last cycle of each READ hold, then advance to the next byte.
  always_comb begin
    idx_d  = idx_q;
    wait_d = wait_q;
    data_d = data_q;
    done_c = 1'b0;
    if (start_i) begin
      idx_d  = '0;
      wait_d = '0;
      data_d = '0;
    end else if (active_i) begin
      if (wait_q == WAIT_W'(READ_LAT)) begin
        data_d[{idx_q, 3'b000} +: 8] = uo_i;
        wait_d = '0;
        if (idx_q == IDX_W'(NB - 1)) begin
          done_c = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      wait_q <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      wait_q <= wait_d;
      data_q <= data_d;
    end
  end

  assign idx_nxt_c = idx_d;
  assign data_o    = data_q;

endmodule

// File: rtl/pe_host_driver.sv
// Host-side initiator for the PE pin protocol: CLEAR/LOAD_A/MAC sequencing and
// byte-wise accumulator readback. Optional MAC counter under PE_DRV_MACCNT_EN.
module pe_host_driver
  import pe_host_pkg::*;
#(
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned READ_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  pe_host_if.slave   host,
  output logic [7:0] pe_ui_in,
  output logic [7:0] pe_uio_in,
  input  logic [7:0] pe_uo_out,
  output logic       pe_ena,
  output logic       busy
);
  pe_state_e state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       last_q, last_d;
  logic [7:0] ui_q, ui_d, uio_q, uio_d;
  logic       op_ready_q, op_ready_d;
  logic       res_valid_q, res_valid_d;
  logic       busy_q, busy_d;
  logic       ena_q;
  logic       hs_c;
  logic [1:0] rb_idx_nxt_c;
  logic       rb_done_c;
  logic [ACC_W-1:0] rb_data;

  assign hs_c = host.op_valid && op_ready_q;

  pe_readback_shifter #(
    .ACC_W    (ACC_W),
    .READ_LAT (READ_LAT)
  ) u_rb (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (state_q == ST_MAC && last_q),
    .active_i  (state_q == ST_RD),
    .uo_i      (pe_uo_out),
    .idx_nxt_c (rb_idx_nxt_c),
    .done_c    (rb_done_c),
    .data_o    (rb_data)
  );

  // Next state plus pin/handshake outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    case (state_q)
      ST_INIT: state_d = ST_CLR;
      ST_CLR:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (hs_c) begin
          a_d     = host.op_a;
          b_d     = host.op_b;
          last_d  = host.op_last;
          state_d = ST_LDA;
        end
      end
      ST_LDA:  state_d = ST_MAC;
      ST_MAC: begin
        if (last_q) begin
          state_d = ST_RD;
        end else if (hs_c) begin
          a_d     = host.op_a;
          b_d     = host.op_b;
          last_d  = host.op_last;
          state_d = ST_LDA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD:   if (rb_done_c) state_d = ST_RES;
      ST_RES:  if (host.res_ready) state_d = ST_CLR;
      default: state_d = ST_INIT;
    endcase

    ui_d  = 8'h00;
    uio_d = pe_uio(PE_CMD_NOP, 2'b00);
    case (state_d)
      ST_CLR: uio_d = pe_uio(PE_CMD_CLEAR, 2'b00);
      ST_LDA: begin
        uio_d = pe_uio(PE_CMD_LOAD_A, 2'b00);
        ui_d  = a_d;
      end
      ST_MAC: begin
        uio_d = pe_uio(PE_CMD_MAC, 2'b00);
        ui_d  = b_d;
      end
      ST_RD:  uio_d = pe_uio(PE_CMD_READ, rb_idx_nxt_c);
      default: ;
    endcase

    op_ready_d  = (state_d == ST_IDLE) || (state_d == ST_MAC && !last_d);
    res_valid_d = (state_d == ST_RES);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      last_q      <= 1'b0;
      ui_q        <= 8'h00;
      uio_q       <= 8'h00;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      ena_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last_q      <= last_d;
      ui_q        <= ui_d;
      uio_q       <= uio_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      ena_q       <= 1'b1;
    end
  end

`ifdef PE_DRV_MACCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, res_count_q, res_count_d;

  // Saturating MAC counter, snapshotted into res_count on entry to RES.
  always_comb begin
    cnt_d       = cnt_q;
    res_count_d = res_count_q;
    if (state_q == ST_CLR) begin
      cnt_d = '0;
    end else if (state_q == ST_MAC && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_d == ST_RES && state_q != ST_RES) begin
      res_count_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      res_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      res_count_q <= res_count_d;
    end
  end

  assign host.res_count = res_count_q;
`else
  assign host.res_count = 16'h0000;
`endif

  assign host.op_ready  = op_ready_q;
  assign host.res_valid = res_valid_q;
  assign host.res_data  = rb_data;
  assign pe_ui_in       = ui_q;
  assign pe_uio_in      = uio_q;
  assign pe_ena         = ena_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_pe_host_driver.sv
// Directed bench for pe_host_driver with a behavioural PE on the pins.
module tb_pe_host_driver;
  localparam int unsigned ACC_W    = 32;
  localparam int unsigned READ_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pe_ui_in, pe_uio_in, pe_uo_out;
  logic       pe_ena, busy;
  int         total = 0;
  int         bad   = 0;

  pe_host_if #(.ACC_W(ACC_W)) hif ();

  pe_host_driver #(.ACC_W(ACC_W), .READ_LAT(READ_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (hif),
    .pe_ui_in  (pe_ui_in),
    .pe_uio_in (pe_uio_in),
    .pe_uo_out (pe_uo_out),
    .pe_ena    (pe_ena),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural PE: LOAD_A/MAC/CLEAR, READ data appears READ_LAT cycles later.
  logic signed [31:0] m_acc = 32'sd0;
  logic signed [7:0]  m_a   = 8'sd0;
  logic [7:0]         m_pipe [READ_LAT];
  initial for (int i = 0; i < READ_LAT; i++) m_pipe[i] = 8'h00;

  always @(posedge clk) begin
    if (pe_ena) begin
      case (pe_uio_in[2:0])
        3'b001: m_a <= $signed(pe_ui_in);
        3'b010: m_acc <= m_acc + m_a * $signed(pe_ui_in);
        3'b100: m_acc <= 32'sd0;
        default: ;
      endcase
      m_pipe[0] <= (pe_uio_in[2:0] == 3'b011) ? m_acc[int'(pe_uio_in[4:3]) * 8 +: 8] : 8'h00;
      for (int i = 1; i < READ_LAT; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end
  assign pe_uo_out = m_pipe[READ_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef PE_DRV_MACCNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic last);
    hif.op_valid = 1'b1;
    hif.op_a     = a;
    hif.op_b     = b;
    hif.op_last  = last;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (hif.res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic res_handshake();
    hif.res_ready = 1'b1;
    tick();
    hif.res_ready = 1'b0;
    chk("hs_clear_uio", 32'(pe_uio_in), 32'h04);
    chk("hs_res_valid_low", 32'(hif.res_valid), 32'h0);
    chk("hs_op_ready_low", 32'(hif.op_ready), 32'h0);
    tick();
    chk("hs_op_ready_back", 32'(hif.op_ready), 32'h1);
  endtask

  logic [7:0]  pa [5] = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h05};
  logic [7:0]  pb [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
  logic [31:0] hold_data;
  logic [15:0] hold_cnt;
  logic [7:0]  e_uio;
  int          lat;

  initial begin
    rst_n         = 1'b0;
    hif.op_valid  = 1'b0;
    hif.op_a      = 8'h00;
    hif.op_b      = 8'h00;
    hif.op_last   = 1'b0;
    hif.res_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_op_ready", 32'(hif.op_ready), 32'h0);
    chk("rst_res_valid", 32'(hif.res_valid), 32'h0);
    chk("rst_res_data", hif.res_data, 32'h0);
    chk("rst_res_count", 32'(hif.res_count), 32'h0);
    chk("rst_ui", 32'(pe_ui_in), 32'h0);
    chk("rst_uio", 32'(pe_uio_in), 32'h0);
    chk("rst_ena", 32'(pe_ena), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);

    rst_n = 1'b1;
    tick();
    chk("init_clear", 32'(pe_uio_in), 32'h04);
    chk("init_ena", 32'(pe_ena), 32'h1);
    chk("init_op_ready", 32'(hif.op_ready), 32'h0);
    tick();
    chk("idle_op_ready", 32'(hif.op_ready), 32'h1);
    chk("idle_uio", 32'(pe_uio_in), 32'h00);
    chk("idle_busy", 32'(busy), 32'h0);

    // Single pair 3*4
    drive(8'h03, 8'h04, 1'b1);
    tick();
    hif.op_valid = 1'b0;
    chk("s_lda_uio", 32'(pe_uio_in), 32'h01);
    chk("s_lda_ui", 32'(pe_ui_in), 32'h03);
    chk("s_lda_ready", 32'(hif.op_ready), 32'h0);
    tick();
    chk("s_mac_uio", 32'(pe_uio_in), 32'h02);
    chk("s_mac_ui", 32'(pe_ui_in), 32'h04);
    chk("s_mac_ready", 32'(hif.op_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        e_uio = 8'h03 | (8'(i) << 3);
        chk("s_read_uio", 32'(pe_uio_in), 32'(e_uio));
        chk("s_read_ui", 32'(pe_ui_in), 32'h0);
      end
    end
    tick();
    chk("s_res_valid", 32'(hif.res_valid), 32'h1);
    chk("s_res_data", hif.res_data, 32'h0000000C);
    chk("s_res_count", 32'(hif.res_count), 32'(exp_cnt(1)));
    chk("s_res_ready", 32'(hif.op_ready), 32'h0);
    res_handshake();

    // Signed back-to-back pairs (-2*5) + (7*-3)
    drive(8'hFE, 8'h05, 1'b0);
    tick();
    chk("b_lda1_uio", 32'(pe_uio_in), 32'h01);
    chk("b_lda1_ui", 32'(pe_ui_in), 32'hFE);
    drive(8'h07, 8'hFD, 1'b1);
    tick();
    chk("b_mac1_ui", 32'(pe_ui_in), 32'h05);
    chk("b_mac1_ready", 32'(hif.op_ready), 32'h1);
    tick();
    hif.op_valid = 1'b0;
    chk("b_lda2_uio", 32'(pe_uio_in), 32'h01);
    chk("b_lda2_ui", 32'(pe_ui_in), 32'h07);
    tick();
    chk("b_mac2_ui", 32'(pe_ui_in), 32'hFD);
    chk("b_mac2_ready", 32'(hif.op_ready), 32'h0);
    wait_res(lat);
    chk("b_latency", 32'(lat), 32'd13);
    chk("b_res_data", hif.res_data, 32'hFFFFFFE1);
    chk("b_res_count", 32'(hif.res_count), 32'(exp_cnt(2)));

    // Result backpressure
    hold_data = hif.res_data;
    hold_cnt  = hif.res_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(hif.res_valid), 32'h1);
      chk("bp_data", hif.res_data, hold_data);
      chk("bp_count", 32'(hif.res_count), 32'(hold_cnt));
      chk("bp_ready", 32'(hif.op_ready), 32'h0);
    end
    res_handshake();

    // Reset during the byte-2 READ wait
    drive(8'h01, 8'h01, 1'b1);
    tick();
    hif.op_valid = 1'b0;
    tick();
    repeat (7) tick();
    chk("r_byte2_uio", 32'(pe_uio_in), 32'h13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_async_uio", 32'(pe_uio_in), 32'h00);
    chk("r_async_valid", 32'(hif.res_valid), 32'h0);
    chk("r_async_busy", 32'(busy), 32'h1);
    chk("r_async_ena", 32'(pe_ena), 32'h0);
    chk("r_async_data", hif.res_data, 32'h0);
    tick();
    tick();
    chk("r_held_valid", 32'(hif.res_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("r_clear_uio", 32'(pe_uio_in), 32'h04);
    tick();
    chk("r_ready", 32'(hif.op_ready), 32'h1);
    drive(8'h02, 8'h03, 1'b1);
    tick();
    hif.op_valid = 1'b0;
    tick();
    wait_res(lat);
    chk("r_latency", 32'(lat), 32'd13);
    chk("r_res_data", hif.res_data, 32'h00000006);
    chk("r_res_count", 32'(hif.res_count), 32'(exp_cnt(1)));
    res_handshake();

    // Five pairs, sum = 1+4+9-4-5 = 5
    for (int i = 0; i < 5; i++) begin
      chk("m_ready", 32'(hif.op_ready), 32'h1);
      drive(pa[i], pb[i], (i == 4));
      tick();
      tick();
    end
    hif.op_valid = 1'b0;
    wait_res(lat);
    chk("m_latency", 32'(lat), 32'd13);
    chk("m_res_data", hif.res_data, 32'h00000005);
    chk("m_res_count", 32'(hif.res_count), 32'(exp_cnt(5)));
    res_handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
